proc_control_unit: RTL and testbench

- Multi-cycle control FSM for the 16-bit processor datapath: eight 16-bit general registers R0..R7, operand register A, ALU result register G and a shared 16-bit bus.
- Each register is an enable-gated 16-bit register on `clock`. This block generates every register load enable, every bus-driver select and the ALU add/sub control.
- It fetches one 9-bit instruction per `run` pulse and sequences it over 2 or 4 cycles.
- Sits between the instruction source (`instr`/`run`) and the register/ALU/bus datapath.

---
 rtl/proc_control_unit.sv | 129 ++++++++++++
 tb/tb_proc_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// Purpose: multi-cycle control FSM for the 16-bit register/ALU/bus datapath.
// Latency: mv/mvi/illegal finish one cycle after fetch, add/sub three cycles after fetch.
// Backpressure: run is only sampled in T0; while busy the start request is ignored.
module proc_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [8:0]       instr,
    output logic [7:0]       rin,
    output logic [7:0]       rout,
    output logic             a_in,
    output logic             g_in,
    output logic             g_out,
    output logic             din_out,
    output logic             add_sub,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t           state_q, state_d;
    logic [8:0]       ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rx_oh, ry_oh;

    // Register-select decodes come from the latched instruction, never from the live input.
    assign rx_oh       = 8'b0000_0001 << ir_q[5:3];
    assign ry_oh       = 8'b0000_0001 << ir_q[2:0];
    assign instr_count = cnt_q;

    // State, instruction register and completion counter; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= 9'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter advances on every final instruction cycle and wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (done) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and all datapath controls; every output defaults to inactive.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        rin     = 8'd0;
        rout    = 8'd0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
        busy    = (state_q != T0);

        case (state_q)
            T0: begin
                // Only a fetch touches IR, so a garbage instr with run low is harmless.
                if (run) begin
                    ir_d    = instr;
                    state_d = T1;
                end
            end
            T1: begin
                case (ir_q[8:6])
                    OP_MV: begin
                        rout    = ry_oh;
                        rin     = rx_oh;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        rin     = rx_oh;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout    = rx_oh;
                        a_in    = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        // Unused opcodes retire as a single-cycle no-op.
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                rout    = ry_oh;
                g_in    = 1'b1;
                add_sub = ir_q[6];
                state_d = T3;
            end
            T3: begin
                g_out   = 1'b1;
                rin     = rx_oh;
                done    = 1'b1;
                state_d = T0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: per-cycle control vectors are queued when an
// instruction is issued and popped against the DUT one cycle at a time.
module tb_proc_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        run, run2;
    logic [8:0]  instr, instr2;

    logic [7:0]  rin, rout, rin_2, rout_2;
    logic        a_in, g_in, g_out, din_out, add_sub, done, busy;
    logic        a_in_2, g_in_2, g_out_2, din_out_2, add_sub_2, done_2, busy_2;
    logic [15:0] instr_count;
    logic [1:0]  instr_count_2;

    logic [22:0] obs, obs2;
    assign obs  = {rin, rout, a_in, g_in, g_out, din_out, add_sub, done, busy};
    assign obs2 = {rin_2, rout_2, a_in_2, g_in_2, g_out_2, din_out_2, add_sub_2, done_2, busy_2};

    logic [22:0] sb[$];
    logic [1:0]  cq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clock = ~clock;

    proc_control_unit dut (
        .clock(clock), .reset(reset), .run(run), .instr(instr),
        .rin(rin), .rout(rout), .a_in(a_in), .g_in(g_in), .g_out(g_out),
        .din_out(din_out), .add_sub(add_sub), .done(done), .busy(busy),
        .instr_count(instr_count)
    );

    proc_control_unit #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .run(run2), .instr(instr2),
        .rin(rin_2), .rout(rout_2), .a_in(a_in_2), .g_in(g_in_2), .g_out(g_out_2),
        .din_out(din_out_2), .add_sub(add_sub_2), .done(done_2), .busy(busy_2),
        .instr_count(instr_count_2)
    );

    function automatic logic [22:0] v(input logic [7:0] ri, input logic [7:0] ro,
                                      input logic a, input logic g, input logic go,
                                      input logic di, input logic as, input logic dn,
                                      input logic bz);
        return {ri, ro, a, g, go, di, as, dn, bz};
    endfunction

    // Reference sequencing of one instruction, one vector per cycle after T0.
    task automatic push_model(input logic [8:0] ins);
        logic [2:0] op;
        logic [7:0] xo, yo;
        op = ins[8:6];
        xo = 8'd1 << ins[5:3];
        yo = 8'd1 << ins[2:0];
        case (op)
            3'b000: sb.push_back(v(xo, yo, 0, 0, 0, 0, 0, 1, 1));
            3'b001: sb.push_back(v(xo, 8'd0, 0, 0, 0, 1, 0, 1, 1));
            3'b010, 3'b011: begin
                sb.push_back(v(8'd0, xo, 1, 0, 0, 0, 0, 0, 1));
                sb.push_back(v(8'd0, yo, 0, 1, 0, 0, op[0], 0, 1));
                sb.push_back(v(xo, 8'd0, 0, 0, 1, 0, 0, 1, 1));
            end
            default: sb.push_back(v(8'd0, 8'd0, 0, 0, 0, 0, 0, 1, 1));
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        run = 1'b0; run2 = 1'b0; instr = 9'd0; instr2 = 9'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); #1;
        n_vec++;
        if (obs !== 23'd0) begin n_err++; $display("FAIL reset_outputs got %h want %h", obs, 23'd0); end
        n_vec++;
        if (instr_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", instr_count); end
        n_vec++;
        if (obs2 !== 23'd0 || instr_count_2 !== 2'd0) begin
            n_err++; $display("FAIL reset_dut2 got %h/%0d want 0/0", obs2, instr_count_2);
        end
    endtask

    // Issues one instruction from T0 and checks every cycle up to the following idle T0.
    task automatic test_instr(input string name, input logic [8:0] ins);
        logic [22:0] e;
        tick();
        instr = ins; run = 1'b1; #1;
        n_vec++;
        if (obs !== 23'd0) begin n_err++; $display("FAIL %s_t0 got %h want %h", name, obs, 23'd0); end
        push_model(ins);
        exp_cnt++;
        while (sb.size() > 0) begin
            tick();
            run = 1'b0; instr = 'x; #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL %s_cycle got %h want %h", name, obs, e); end
        end
        tick(); #1;
        n_vec++;
        if (obs !== 23'd0 || instr_count !== exp_cnt) begin
            n_err++; $display("FAIL %s_idle got %h/%0d want %h/%0d", name, obs, instr_count, 23'd0, exp_cnt);
        end
    endtask

    task automatic test_sub_run_ignored();
        logic [22:0] e;
        tick();
        instr = 9'b011_001_110; run = 1'b1; #1;
        n_vec++;
        if (obs !== 23'd0) begin n_err++; $display("FAIL sub_t0 got %h want %h", obs, 23'd0); end
        sb.push_back(v(8'h00, 8'h02, 1, 0, 0, 0, 0, 0, 1));
        sb.push_back(v(8'h00, 8'h40, 0, 1, 0, 0, 1, 0, 1));
        sb.push_back(v(8'h02, 8'h00, 0, 0, 1, 0, 0, 1, 1));
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            run = (i == 1);
            instr = 9'b001_111_000;
            #1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL sub_T%0d got %h want %h", i + 1, obs, e); end
        end
        run = 1'b0;
        tick(); #1;
        n_vec++;
        if (obs !== 23'd0 || instr_count !== exp_cnt) begin
            n_err++; $display("FAIL sub_idle got %h/%0d want %h/%0d", obs, instr_count, 23'd0, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        instr = 9'b010_000_001; run = 1'b1; #1;
        tick();
        run = 1'b0; #1;
        n_vec++;
        if (obs !== v(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 1)) begin
            n_err++; $display("FAIL rmid_T1 got %h want %h", obs, v(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 1));
        end
        tick(); #1;
        n_vec++;
        if (obs !== v(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 1)) begin
            n_err++; $display("FAIL rmid_T2 got %h want %h", obs, v(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 1));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        exp_cnt = 16'd0;
        n_vec++;
        if (obs !== 23'd0 || instr_count !== 16'd0) begin
            n_err++; $display("FAIL rmid_after got %h/%0d want %h/0", obs, instr_count, 23'd0);
        end
        tick(); #1;
        n_vec++;
        if (obs !== 23'd0 || instr_count !== 16'd0) begin
            n_err++; $display("FAIL rmid_quiet got %h/%0d want %h/0", obs, instr_count, 23'd0);
        end
    endtask

    // run held high on the 2-bit-counter instance: fetch every other cycle, counter wraps.
    task automatic test_back_to_back();
        logic [22:0] e;
        logic [1:0]  c;
        logic [2:0]  r;
        tick();
        run2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r = 3'(i);
            instr2 = {3'b001, r, 3'b000};
            #1;
            n_vec++;
            if (obs2 !== 23'd0) begin n_err++; $display("FAIL b2b_t0_%0d got %h want %h", i, obs2, 23'd0); end
            sb.push_back(v(8'd1 << r, 8'd0, 0, 0, 0, 1, 0, 1, 1));
            cq.push_back(2'(i + 1));
            tick(); #1;
            e = sb.pop_front();
            n_vec++;
            if (obs2 !== e) begin n_err++; $display("FAIL b2b_t1_%0d got %h want %h", i, obs2, e); end
            tick(); #1;
            c = cq.pop_front();
            n_vec++;
            if (instr_count_2 !== c) begin
                n_err++; $display("FAIL b2b_count_%0d got %0d want %0d", i, instr_count_2, c);
            end
        end
        run2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_instr("mvi", 9'b001_010_000);
        test_instr("mv", 9'b000_101_011);
        test_sub_run_ignored();
        test_instr("illegal", 9'b111_000_000);
        test_instr("add_self", 9'b010_011_011);
        test_instr("mv_self", 9'b000_110_110);
        test_instr("nop100", 9'b100_111_010);
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
